death_respawn_ctrl: RTL and testbench
=====================================

Name: death_respawn_ctrl

Overview:
Sequences the player death/respawn cycle while a level is being played. It watches the per-level active flags from the game FSM and a collision hit from the enemy logic. On a death it freezes player motion and fades the screen out, issues a respawn and coin-clear pulse, then fades back in. It also keeps a saturating BCD death counter for the HUD.

Parameters:
FADE_STEPS, 8, frame ticks per fade direction; legal range 1..15.
L1_X, 10'd40, level 1 spawn X (pixels).
L1_Y, 10'd240, level 1 spawn Y.
L2_X, 10'd40, level 2 spawn X.
L2_Y, 10'd200, level 2 spawn Y.
L3_X, 10'd60, level 3 spawn X.
L3_Y, 10'd400, level 3 spawn Y.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-Clk pulse per video frame
Level1_Active  in  1  level 1 being played
Level2_Active  in  1  level 2 being played
Level3_Active  in  1  level 3 being played
Hit  in  1  player/enemy collision, level-sensitive
Freeze  out  1  inhibit player movement
Respawn  out  1  one-cycle pulse: load Spawn_X/Spawn_Y into the player
Coin_Clear  out  1  one-cycle pulse: un-collect the current level's coin
Spawn_X  out  10  spawn X for the current level
Spawn_Y  out  10  spawn Y for the current level
Fade_Level  out  4  0 = clear, FADE_STEPS = black
Deaths  out  12  BCD death count, 3 digits [11:8]=hundreds
Deaths_Sat  out  1  Deaths has reached 999

Behaviour:
- Reset (async, any time): state IDLE. Freeze=0, Respawn=0, Coin_Clear=0, Fade_Level=0, Deaths=0, Deaths_Sat=0, Spawn_X/Y=L1_X/L1_Y. All outputs are registered.
- Active level = first high of Level1/2/3_Active, in priority L1 > L2 > L3. "Any_Active" = OR of the three.
- States: IDLE, ALIVE, FADE_OUT, RESPAWN, FADE_IN.
- IDLE: when Any_Active is high, go to ALIVE and load Spawn_X/Y from the active level's parameters. The outputs update on the same edge.
- ALIVE:
  - If Any_Active is low, go to IDLE.
  - Else if Hit is high, go to FADE_OUT: set Freeze=1, keep Fade_Level=0, and increment Deaths on that edge.
  - Hit is sampled only in ALIVE and ignored in all other states.
- Deaths arithmetic: BCD increment with digit carry (009 -> 010, 099 -> 100). At 999 the counter holds and Deaths_Sat=1. Deaths is cleared only by Reset and survives level changes.
- FADE_OUT: on each frame_tick, if Fade_Level==FADE_STEPS go to RESPAWN, else Fade_Level+1. Black is therefore held for one full frame.
- RESPAWN: lasts exactly one cycle with Respawn=1, Coin_Clear=1 and Freeze=1. Next state is FADE_IN; Fade_Level is unchanged.
- FADE_IN: on each frame_tick, if Fade_Level==0 go to ALIVE with Freeze=0, else Fade_Level-1.
- Freeze is high exactly in FADE_OUT, RESPAWN and FADE_IN.
- Level drop mid-sequence: Any_Active low in FADE_OUT, RESPAWN or FADE_IN goes to IDLE on the next edge. That edge clears Freeze, Fade_Level and the pulses; Deaths is retained.
- Simultaneous events:
  - Hit together with a level drop in ALIVE: the drop wins, no death is counted, go to IDLE.
  - Active level changes while in ALIVE (e.g. L1 to L2 with no IDLE gap): reload Spawn_X/Y on the next edge and stay in ALIVE.
- frame_tick arriving in the same cycle a state is entered is not counted; counting starts the following cycle.
- Latency:
  - Hit to Freeze: 1 cycle.
  - Hit to Respawn: (FADE_STEPS+1) frame_ticks plus 1 cycle.
  - Respawn to Freeze release: (FADE_STEPS+1) frame_ticks.

Test Plan:
- Reset, then Level1_Active=1 -> next edge: ALIVE, Spawn_X=40, Spawn_Y=240, Freeze=0, Deaths=0x000.
- FADE_STEPS=4, L2 active, 1-cycle Hit, frame_tick every 10 cycles:
  - Freeze=1 and Deaths=0x001 one cycle after Hit.
  - Fade_Level runs 1,2,3,4; Respawn and Coin_Clear each pulse 1 cycle after the 5th tick.
  - Fade_Level then runs 3,2,1,0; Freeze drops after the 5th tick in FADE_IN.
- Hit held high through the whole sequence -> Deaths increments once per death only. A new death starts on the first ALIVE cycle after fade-in.
- Deaths preloaded via 999 deaths: one more Hit -> Deaths stays 0x999 and Deaths_Sat=1. Carry check: 0x099 -> 0x100.
- Level2_Active dropped while Fade_Level=2 in FADE_OUT -> next edge: IDLE, Freeze=0, Fade_Level=0, no Respawn pulse, Deaths unchanged.
- Hit and Level1_Active falling in the same cycle -> IDLE, Deaths unchanged. Reset asserted during FADE_IN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/death_respawn_ctrl.sv
// Player death/respawn sequencer: freeze + fade out, one-cycle respawn/coin-clear pulse, fade in.
// All outputs registered; Hit to Freeze is one cycle, fades advance on frame_tick only.
module death_respawn_ctrl #(
    parameter int         FADE_STEPS = 8,
    parameter logic [9:0] L1_X       = 10'd40,
    parameter logic [9:0] L1_Y       = 10'd240,
    parameter logic [9:0] L2_X       = 10'd40,
    parameter logic [9:0] L2_Y       = 10'd200,
    parameter logic [9:0] L3_X       = 10'd60,
    parameter logic [9:0] L3_Y       = 10'd400
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        Level1_Active,
    input  logic        Level2_Active,
    input  logic        Level3_Active,
    input  logic        Hit,
    output logic        Freeze,
    output logic        Respawn,
    output logic        Coin_Clear,
    output logic [9:0]  Spawn_X,
    output logic [9:0]  Spawn_Y,
    output logic [3:0]  Fade_Level,
    output logic [11:0] Deaths,
    output logic        Deaths_Sat
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ALIVE    = 3'd1;
    localparam logic [2:0] FADE_OUT = 3'd2;
    localparam logic [2:0] RESPAWN  = 3'd3;
    localparam logic [2:0] FADE_IN  = 3'd4;

    localparam logic [3:0] FADE_MAX = 4'(FADE_STEPS);

    logic [2:0]  r_state;
    logic [3:0]  r_fade;
    logic        r_freeze;
    logic        r_respawn;
    logic        r_coin_clear;
    logic [9:0]  r_spawn_x;
    logic [9:0]  r_spawn_y;
    logic [11:0] r_deaths;
    logic        r_sat;

    logic        w_any;
    logic [9:0]  w_spawn_x;
    logic [9:0]  w_spawn_y;
    logic [2:0]  w_nxt_state;
    logic [3:0]  w_nxt_fade;
    logic        w_death;
    logic [11:0] w_deaths_inc;

    assign w_any = Level1_Active | Level2_Active | Level3_Active;

    always_comb begin
        w_spawn_x = L3_X;
        w_spawn_y = L3_Y;
        if (Level1_Active) begin
            w_spawn_x = L1_X;
            w_spawn_y = L1_Y;
        end else if (Level2_Active) begin
            w_spawn_x = L2_X;
            w_spawn_y = L2_Y;
        end
    end

    // Level drop outranks every other event, including a same-cycle Hit.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_fade  = r_fade;
        case (r_state)
            IDLE: begin
                if (w_any) w_nxt_state = ALIVE;
            end
            ALIVE: begin
                if (!w_any)   w_nxt_state = IDLE;
                else if (Hit) w_nxt_state = FADE_OUT;
            end
            FADE_OUT: begin
                if (!w_any) begin
                    w_nxt_state = IDLE;
                    w_nxt_fade  = 4'd0;
                end else if (frame_tick) begin
                    if (r_fade == FADE_MAX) w_nxt_state = RESPAWN;
                    else                    w_nxt_fade  = r_fade + 4'd1;
                end
            end
            RESPAWN: begin
                if (!w_any) begin
                    w_nxt_state = IDLE;
                    w_nxt_fade  = 4'd0;
                end else begin
                    w_nxt_state = FADE_IN;
                end
            end
            FADE_IN: begin
                if (!w_any) begin
                    w_nxt_state = IDLE;
                    w_nxt_fade  = 4'd0;
                end else if (frame_tick) begin
                    if (r_fade == 4'd0) w_nxt_state = ALIVE;
                    else                w_nxt_fade  = r_fade - 4'd1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_fade  = 4'd0;
            end
        endcase
    end

    assign w_death = (r_state == ALIVE) && w_any && Hit;

    // Three-digit BCD increment with ripple carry between digits.
    always_comb begin
        w_deaths_inc = r_deaths;
        if (r_deaths[3:0] != 4'd9) begin
            w_deaths_inc[3:0] = r_deaths[3:0] + 4'd1;
        end else begin
            w_deaths_inc[3:0] = 4'd0;
            if (r_deaths[7:4] != 4'd9) begin
                w_deaths_inc[7:4] = r_deaths[7:4] + 4'd1;
            end else begin
                w_deaths_inc[7:4]  = 4'd0;
                w_deaths_inc[11:8] = r_deaths[11:8] + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_fade       <= 4'd0;
            r_freeze     <= 1'b0;
            r_respawn    <= 1'b0;
            r_coin_clear <= 1'b0;
            r_spawn_x    <= L1_X;
            r_spawn_y    <= L1_Y;
            r_deaths     <= 12'h000;
            r_sat        <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_fade       <= w_nxt_fade;
            r_freeze     <= (w_nxt_state == FADE_OUT) || (w_nxt_state == RESPAWN) ||
                            (w_nxt_state == FADE_IN);
            r_respawn    <= (w_nxt_state == RESPAWN);
            r_coin_clear <= (w_nxt_state == RESPAWN);
            if (((r_state == IDLE) || (r_state == ALIVE)) && w_any) begin
                r_spawn_x <= w_spawn_x;
                r_spawn_y <= w_spawn_y;
            end
            if (w_death && !r_sat) begin
                r_deaths <= w_deaths_inc;
                r_sat    <= (w_deaths_inc == 12'h999);
            end
        end
    end

    assign Freeze     = r_freeze;
    assign Respawn    = r_respawn;
    assign Coin_Clear = r_coin_clear;
    assign Spawn_X    = r_spawn_x;
    assign Spawn_Y    = r_spawn_y;
    assign Fade_Level = r_fade;
    assign Deaths     = r_deaths;
    assign Deaths_Sat = r_sat;

endmodule

// File: tb/tb_death_respawn_ctrl.sv
// Directed bench for death_respawn_ctrl with FADE_STEPS=4.
module tb_death_respawn_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        Level1_Active;
    logic        Level2_Active;
    logic        Level3_Active;
    logic        Hit;
    logic        Freeze;
    logic        Respawn;
    logic        Coin_Clear;
    logic [9:0]  Spawn_X;
    logic [9:0]  Spawn_Y;
    logic [3:0]  Fade_Level;
    logic [11:0] Deaths;
    logic        Deaths_Sat;

    int n_checks = 0;
    int n_errors = 0;

    death_respawn_ctrl #(.FADE_STEPS(4)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .Level1_Active(Level1_Active), .Level2_Active(Level2_Active),
        .Level3_Active(Level3_Active), .Hit(Hit),
        .Freeze(Freeze), .Respawn(Respawn), .Coin_Clear(Coin_Clear),
        .Spawn_X(Spawn_X), .Spawn_Y(Spawn_Y), .Fade_Level(Fade_Level),
        .Deaths(Deaths), .Deaths_Sat(Deaths_Sat)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Nine quiet cycles, then one cycle with frame_tick high.
    task automatic slow_tick();
        frame_tick = 1'b0;
        repeat (9) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; Hit = 1'b0;
        Level1_Active = 1'b0; Level2_Active = 1'b0; Level3_Active = 1'b0;
        repeat (3) step();
        chk("rst_freeze", 32'(Freeze), 0);
        chk("rst_fade",   32'(Fade_Level), 0);
        chk("rst_deaths", 32'(Deaths), 32'h000);
        chk("rst_spawnx", 32'(Spawn_X), 40);
        chk("rst_spawny", 32'(Spawn_Y), 240);
        Reset = 1'b0;
        step();

        // Enter level 1
        Level1_Active = 1'b1;
        step();
        chk("l1_spawnx", 32'(Spawn_X), 40);
        chk("l1_spawny", 32'(Spawn_Y), 240);
        chk("l1_freeze", 32'(Freeze), 0);
        chk("l1_deaths", 32'(Deaths), 32'h000);

        // Direct L1 -> L2 switch reloads spawn
        Level1_Active = 1'b0; Level2_Active = 1'b1;
        step();
        chk("l2_spawnx", 32'(Spawn_X), 40);
        chk("l2_spawny", 32'(Spawn_Y), 200);

        // One-cycle Hit with a coincident frame_tick that must not count
        Hit = 1'b1; frame_tick = 1'b1;
        step();
        Hit = 1'b0; frame_tick = 1'b0;
        chk("hit_freeze", 32'(Freeze), 1);
        chk("hit_deaths", 32'(Deaths), 32'h001);
        chk("hit_fade0",  32'(Fade_Level), 0);
        for (int k = 1; k <= 4; k++) begin
            slow_tick();
            chk("fo_fade", 32'(Fade_Level), 32'(k));
            chk("fo_norsp", 32'(Respawn), 0);
        end
        slow_tick();
        chk("rsp_pulse", 32'(Respawn), 1);
        chk("rsp_coin",  32'(Coin_Clear), 1);
        chk("rsp_freeze", 32'(Freeze), 1);
        chk("rsp_fade",  32'(Fade_Level), 4);
        step();
        chk("rsp_end",   32'(Respawn), 0);
        chk("coin_end",  32'(Coin_Clear), 0);
        chk("fi_fade4",  32'(Fade_Level), 4);
        for (int k = 3; k >= 0; k--) begin
            slow_tick();
            chk("fi_fade", 32'(Fade_Level), 32'(k));
            chk("fi_freeze", 32'(Freeze), 1);
        end
        slow_tick();
        chk("fi_release", 32'(Freeze), 0);
        chk("fi_fadeclr", 32'(Fade_Level), 0);

        // Hit held high, frame_tick every cycle: one death per 12 cycles
        Hit = 1'b1; frame_tick = 1'b1;
        step();
        chk("hold_d2", 32'(Deaths), 32'h002);
        repeat (11) step();
        chk("hold_alive", 32'(Freeze), 0);
        chk("hold_once",  32'(Deaths), 32'h002);
        step();
        chk("hold_refrz", 32'(Freeze), 1);
        chk("hold_d3",    32'(Deaths), 32'h003);
        Hit = 1'b0;
        repeat (11) step();
        chk("hold_done", 32'(Freeze), 0);
        frame_tick = 1'b0;

        // Level drop mid fade-out
        Hit = 1'b1;
        step();
        Hit = 1'b0;
        chk("drop_d4", 32'(Deaths), 32'h004);
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        chk("drop_fade2", 32'(Fade_Level), 2);
        Level2_Active = 1'b0;
        step();
        chk("drop_freeze", 32'(Freeze), 0);
        chk("drop_fade",   32'(Fade_Level), 0);
        chk("drop_rsp",    32'(Respawn), 0);
        chk("drop_deaths", 32'(Deaths), 32'h004);
        step();
        chk("drop_norsp", 32'(Respawn), 0);

        // Hit coincident with level-1 drop: no death
        Level1_Active = 1'b1;
        step();
        Hit = 1'b1; Level1_Active = 1'b0;
        step();
        Hit = 1'b0;
        chk("hitdrop_frz", 32'(Freeze), 0);
        chk("hitdrop_d",   32'(Deaths), 32'h004);

        // Level 3 spawn
        Level3_Active = 1'b1;
        step();
        chk("l3_spawnx", 32'(Spawn_X), 60);
        chk("l3_spawny", 32'(Spawn_Y), 400);

        // Async reset during fade-in
        Hit = 1'b1;
        step();
        Hit = 1'b0; frame_tick = 1'b1;
        repeat (7) step();
        frame_tick = 1'b0;
        chk("pre_rst_fade", 32'(Fade_Level), 3);
        chk("pre_rst_frz",  32'(Freeze), 1);
        Reset = 1'b1;
        #1;
        chk("arst_freeze", 32'(Freeze), 0);
        chk("arst_fade",   32'(Fade_Level), 0);
        chk("arst_deaths", 32'(Deaths), 32'h000);
        chk("arst_spawny", 32'(Spawn_Y), 240);
        step();
        Reset = 1'b0;
        Level3_Active = 1'b0;
        step();

        // Run deaths up to saturation, every cycle a frame tick, Hit held
        Level1_Active = 1'b1; Hit = 1'b1; frame_tick = 1'b1;
        step();
        step();
        chk("sat_d1", 32'(Deaths), 32'h001);
        for (int i = 2; i <= 999; i++) begin
            repeat (12) step();
            if (i == 9)   chk("bcd_009", 32'(Deaths), 32'h009);
            if (i == 10)  chk("bcd_010", 32'(Deaths), 32'h010);
            if (i == 99)  chk("bcd_099", 32'(Deaths), 32'h099);
            if (i == 100) chk("bcd_100", 32'(Deaths), 32'h100);
            if (i == 998) chk("sat_998", 32'(Deaths_Sat), 0);
        end
        chk("sat_999", 32'(Deaths), 32'h999);
        chk("sat_flag", 32'(Deaths_Sat), 1);
        repeat (12) step();
        chk("sat_hold_frz", 32'(Freeze), 1);
        chk("sat_hold", 32'(Deaths), 32'h999);
        chk("sat_hold_flag", 32'(Deaths_Sat), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
